// File: rtl/bitwise_accumulator.sv
// Command-driven bitwise accumulator with a snapshot output FIFO.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_op/in_data
// command input; acc current accumulator; out_valid/out_ready/out_data/
// out_ops FIFO head carrying {accumulator, op count} snapshots.
module bitwise_accumulator #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [3:0]       out_ops
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    localparam logic [2:0] OP_LOAD = 3'd0;
    localparam logic [2:0] OP_AND  = 3'd1;
    localparam logic [2:0] OP_OR   = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_XNOR = 3'd6;
    localparam logic [2:0] OP_READ = 3'd7;

    logic [3:0]       ops_cnt;
    logic [WIDTH-1:0] acc_nxt;
    logic [3:0]       ops_nxt;

    logic [WIDTH-1:0] mem_data [DEPTH];
    logic [3:0]       mem_ops  [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    logic accept;
    logic push;
    logic pop;

    // in_ready depends only on registered occupancy
    assign in_ready  = (count != FULL_CNT);
    assign out_valid = (count != '0);

    // reset wins over any command presented in the same cycle
    assign accept = in_valid && in_ready && !rst;
    assign push   = accept && (in_op == OP_READ);
    assign pop    = out_valid && out_ready && !rst;

    assign out_data = out_valid ? mem_data[rd_ptr] : '0;
    assign out_ops  = out_valid ? mem_ops[rd_ptr]  : '0;

    always_comb begin
        acc_nxt = acc;
        ops_nxt = ops_cnt;
        case (in_op)
            OP_LOAD: begin
                acc_nxt = in_data;
                ops_nxt = '0;
            end
            OP_AND:  acc_nxt = acc & in_data;
            OP_OR:   acc_nxt = acc | in_data;
            OP_NAND: acc_nxt = ~(acc & in_data);
            OP_NOR:  acc_nxt = ~(acc | in_data);
            OP_XOR:  acc_nxt = acc ^ in_data;
            OP_XNOR: acc_nxt = ~(acc ^ in_data);
            default: acc_nxt = acc;
        endcase
        // logic ops count up, saturating at 15
        if ((in_op != OP_LOAD) && (in_op != OP_READ) &&
            (ops_cnt != 4'hF)) begin
            ops_nxt = ops_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            ops_cnt <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else begin
            if (accept) begin
                acc     <= acc_nxt;
                ops_cnt <= ops_nxt;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // storage needs no reset; validity is tracked by count
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= acc;
            mem_ops[wr_ptr]  <= ops_cnt;
        end
    end

endmodule
